// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes kb_clock/kb_data, deframes 11-bit
// frames, and folds 0xF0/0xE0 prefixes into flags on the following scan code.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic [7:0] raw_data,
  output logic       code_valid,
  output logic       released,
  output logic       extended,
  output logic [7:0] held_code,
  output logic       frame_err,
  output logic [1:0] fsm_state
);

  // Output protocol: code_valid and frame_err are single-cycle strobes with no
  // back-pressure; raw_data/released/extended/held_code are stable between
  // strobes and may be sampled on any cycle in which code_valid is high.

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state, state_n;

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          break_pending, ext_pending;

  logic          start_en, shift_en, parity_en, frame_end, timeout_hit;
  logic          frame_good;

  assign fall       = clk_s3 & ~clk_s2;
  assign frame_good = dat_s2 & (^{shift_reg, parity_bit});
  assign fsm_state  = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= kb_clock;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= kb_data;
      dat_s2 <= dat_s1;
    end
  end

  always_comb begin
    state_n     = state;
    start_en    = 1'b0;
    shift_en    = 1'b0;
    parity_en   = 1'b0;
    frame_end   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          start_en = 1'b1;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_en = 1'b1;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          frame_end = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A falling edge wins over an expiring timeout in the same cycle.
    if (state != IDLE && !fall && tmo_cnt == TMO_MAX) begin
      timeout_hit = 1'b1;
      state_n     = IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (start_en) bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg <= {dat_s2, shift_reg[7:1]};
      if (parity_en) parity_bit <= dat_s2;
      if (state == IDLE || fall || timeout_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      raw_data      <= 8'h00;
      held_code     <= 8'h00;
      code_valid    <= 1'b0;
      released      <= 1'b0;
      extended      <= 1'b0;
      frame_err     <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout_hit) begin
        frame_err     <= 1'b1;
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end else if (frame_end) begin
        if (!frame_good) begin
          frame_err     <= 1'b1;
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
        end else if (shift_reg == 8'hF0) begin
          break_pending <= 1'b1;
        end else if (shift_reg == 8'hE0) begin
          ext_pending <= 1'b1;
        end else begin
          raw_data      <= shift_reg;
          released      <= break_pending;
          extended      <= ext_pending;
          code_valid    <= 1'b1;
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
          // Only plain codes track the held key; a break releases it only if it matches.
          if (!ext_pending) begin
            if (!break_pending) held_code <= shift_reg;
            else if (shift_reg == held_code) held_code <= 8'h00;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: driver pushes hand-computed responses,
// a negedge monitor pops and compares on every code_valid/frame_err strobe.
module tb_ps2_scancode_rx;

  localparam int TMO  = 200;
  localparam int HALF = 20;
  localparam int W    = 19;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       kb_clock = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] raw_data;
  logic       code_valid;
  logic       released;
  logic       extended;
  logic [7:0] held_code;
  logic       frame_err;
  logic [1:0] fsm_state;

  int vectors = 0;
  int errors  = 0;

  // {is_err, released, extended, raw_data, held_code}
  logic [W-1:0] exp_q[$];

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .kb_clock   (kb_clock),
    .kb_data    (kb_data),
    .raw_data   (raw_data),
    .code_valid (code_valid),
    .released   (released),
    .extended   (extended),
    .held_code  (held_code),
    .frame_err  (frame_err),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic ps2_bit(input logic b);
    kb_data = b;
    repeat (HALF) @(posedge clock);
    kb_clock = 1'b0;
    repeat (HALF) @(posedge clock);
    kb_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    kb_data = 1'b1;
    repeat (3 * HALF) @(posedge clock);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic exp_code(input logic rel, input logic ext, input logic [7:0] raw, input logic [7:0] held);
    exp_q.push_back({1'b0, rel, ext, raw, held});
  endtask

  task automatic exp_err(input logic rel, input logic ext, input logic [7:0] raw, input logic [7:0] held);
    exp_q.push_back({1'b1, rel, ext, raw, held});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (resetn && (code_valid || frame_err)) begin
      logic [W-1:0] act;
      logic [W-1:0] req;
      act = {frame_err, released, extended, raw_data, held_code};
      vectors++;
      if (code_valid && frame_err) begin
        errors++;
        $display("FAIL strobe_overlap: code_valid and frame_err both high at %0t", $time);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got {err,rel,ext,raw,held}=%h with empty queue", act);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          errors++;
          $display("FAIL strobe_fields: got {err,rel,ext,raw,held}=%h, expected %h", act, req);
        end
      end
    end
  end

  initial begin
    repeat (5) @(posedge clock);
    #1;
    check("reset_raw_data",   raw_data, 8'h00);
    check("reset_held_code",  held_code, 8'h00);
    check("reset_code_valid", {7'd0, code_valid}, 8'h00);
    check("reset_released",   {7'd0, released}, 8'h00);
    check("reset_extended",   {7'd0, extended}, 8'h00);
    check("reset_frame_err",  {7'd0, frame_err}, 8'h00);
    check("reset_fsm_state",  {6'd0, fsm_state}, 8'h00);
    resetn = 1'b1;
    repeat (5) @(posedge clock);

    exp_code(1'b0, 1'b0, 8'h1C, 8'h1C); good(8'h1C);
    good(8'hF0); exp_code(1'b1, 1'b0, 8'h1C, 8'h00); good(8'h1C);
    exp_code(1'b0, 1'b0, 8'h23, 8'h23); good(8'h23);
    good(8'hE0); exp_code(1'b0, 1'b1, 8'h75, 8'h23); good(8'h75);

    // Bad parity, bad stop: outputs frozen.
    exp_err(1'b0, 1'b1, 8'h75, 8'h23); send_frame(8'h1C, 1'b1, 1'b1);
    exp_err(1'b0, 1'b1, 8'h75, 8'h23); send_frame(8'h1C, 1'b0, 1'b0);

    // A bad frame drops a pending break prefix.
    good(8'hF0);
    exp_err(1'b0, 1'b1, 8'h75, 8'h23); send_frame(8'h1C, 1'b1, 1'b1);
    exp_code(1'b0, 1'b0, 8'h1C, 8'h1C); good(8'h1C);

    // Break of a key that is not held leaves held_code alone.
    good(8'hF0); exp_code(1'b1, 1'b0, 8'h23, 8'h1C); good(8'h23);

    // Timeout after start + 4 data bits also drops a pending extended prefix.
    good(8'hE0);
    exp_err(1'b1, 1'b0, 8'h23, 8'h1C);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    kb_data = 1'b1;
    repeat (TMO + 50) @(posedge clock);
    #1;
    check("timeout_fsm_idle", {6'd0, fsm_state}, 8'h00);
    exp_code(1'b0, 1'b0, 8'h23, 8'h23); good(8'h23);

    // Reset during data bit 5.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    kb_data = 1'b0;
    repeat (HALF) @(posedge clock);
    kb_clock = 1'b0;
    repeat (HALF / 2) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check("midreset_raw_data",  raw_data, 8'h00);
    check("midreset_held_code", held_code, 8'h00);
    check("midreset_flags",     {4'd0, code_valid, released, extended, frame_err}, 8'h00);
    check("midreset_fsm_state", {6'd0, fsm_state}, 8'h00);
    repeat (HALF / 2) @(posedge clock);
    kb_clock = 1'b1;
    kb_data  = 1'b1;
    repeat (5) @(posedge clock);
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    exp_code(1'b0, 1'b0, 8'h24, 8'h24); good(8'h24);

    repeat (100) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size()[7:0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning system clocks without a kb_clock falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
REQ-002 The block SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port kb_clock  input  1  raw PS/2 clock from keyboard, asynchronous to clock.
REQ-005 The block SHALL have port kb_data  input  1  raw PS/2 data from keyboard, asynchronous to clock.
REQ-006 The block SHALL have port raw_data  output  8  last accepted non-prefix scan code; feeds convert_readable.raw_data.
REQ-007 The block SHALL have port code_valid  output  1  one-clock pulse when raw_data, released and extended update.
REQ-008 The block SHALL have port released  output  1  raw_data was preceded by an 0xF0 break prefix.
REQ-009 The block SHALL have port extended  output  1  raw_data was preceded by an 0xE0 prefix.
REQ-010 The block SHALL have port held_code  output  8  currently held non-extended make code; 0x00 when none.
REQ-011 The block SHALL have port frame_err  output  1  one-clock pulse on parity, stop-bit or timeout error.

Function
REQ-012 The block SHALL pass kb_clock and kb_data each through a two-flop synchronizer, plus one further kb_clock stage for edge detection.
REQ-013 The block SHALL treat a falling edge as previous synchronized kb_clock = 1 and current = 0; kb_data SHALL be sampled from its synchronized value in that same cycle.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 In IDLE, a falling edge with data = 0 SHALL go to DATA with bit count 0; with data = 1 it SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-016 In DATA, each falling edge SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-017 In PARITY, the falling edge SHALL capture the parity bit and go to STOP.
REQ-018 In STOP, the falling edge SHALL end the frame and return to IDLE; the frame is good only if stop = 1 and the 8 data bits plus the parity bit contain an odd number of ones.
REQ-019 A bad frame SHALL pulse frame_err for one clock, clear both prefix flags, and leave raw_data, released, extended and held_code unchanged.
REQ-020 A timeout counter SHALL reset to 0 on every falling edge and in IDLE; outside IDLE, reaching TIMEOUT_CYCLES-1 SHALL abort to IDLE, pulse frame_err and clear the prefix flags.
REQ-021 A good byte 0xF0 SHALL set break_pending and a good byte 0xE0 SHALL set ext_pending; neither SHALL pulse code_valid.
REQ-022 Any other good byte SHALL, on the clock edge that processes the stop-bit falling edge, update:
- raw_data = byte
- released = break_pending
- extended = ext_pending
- break_pending and ext_pending cleared
- code_valid high for exactly the following clock.
REQ-023 For a non-extended code, held_code SHALL be set to the byte on make; on break, held_code SHALL become 0x00 only if the byte equals held_code.
REQ-024 An extended code SHALL never change held_code.
REQ-025 code_valid and frame_err SHALL never be high in the same cycle.
REQ-026 A kb_clock falling edge coinciding with a timeout SHALL be handled as an edge, and the counter SHALL restart.

Reset
REQ-027 While resetn = 0, the block SHALL force:
- outputs: raw_data = 0x00, held_code = 0x00, code_valid = 0, released = 0, extended = 0, frame_err = 0
- internal: FSM IDLE, bit count 0, timeout counter 0, both prefix flags 0, synchronizers to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; decoding SHALL resume only on a fresh start bit after release.

Verification
REQ-029 Frame 0x1C (parity 0, stop 1) -> one code_valid pulse; raw_data = 0x1C, released = 0, extended = 0, held_code = 0x1C.
REQ-030 After REQ-029, frames 0xF0 then 0x1C -> exactly one code_valid pulse; raw_data = 0x1C, released = 1, held_code = 0x00.
REQ-031 Frames 0xE0 then 0x75 with held_code = 0x23 -> raw_data = 0x75, extended = 1, released = 0, held_code stays 0x23.
REQ-032 Frame 0x1C with parity bit 1, and separately a frame with stop bit 0 -> one frame_err pulse each, no code_valid, outputs unchanged.
REQ-033 Start bit plus 4 data bits, then kb_clock idle for TIMEOUT_CYCLES -> one frame_err pulse, FSM back in IDLE; the next 0x23 frame decodes to raw_data = 0x23.
REQ-034 resetn pulsed low during data bit 5 -> all outputs 0 immediately; the next 0x24 frame decodes to raw_data = 0x24 with no frame_err.
